// File: rtl/zigzag_reorder_pp.sv
// Coefficient reorder stage: accepts N x N blocks in raster order into a
// ping-pong pair of block RAMs and emits each block in the scan order that
// was selected when its first coefficient arrived (zigzag, raster or
// column-major). Ready/valid on both sides, one coefficient per cycle.
module zigzag_reorder_pp #(
    parameter int DATA_WIDTH = 10,
    parameter int N          = 8,
    parameter int IDX_W      = 2 * $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sop,
    input  logic [1:0]            mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  sop_err
);

    localparam int                LOG_N    = $clog2(N);
    localparam int                BLK      = N * N;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLK - 1);
    localparam logic [LOG_N-1:0]  EDGE     = LOG_N'(N - 1);

    typedef enum logic [1:0] {
        SCAN_ZIGZAG     = 2'd0,
        SCAN_RASTER     = 2'd1,
        SCAN_COLUMN     = 2'd2,
        SCAN_ZIGZAG_ALT = 2'd3
    } scan_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [IDX_W-1:0]      idx;
        logic                  sop;
        logic                  eop;
    } beat_t;

    // Both banks live in one array; the bank select is the top address bit.
    logic [DATA_WIDTH-1:0] mem_q [2*BLK];

    // Write side state
    logic             wb_q, wb_d;
    logic [IDX_W-1:0] wc_q, wc_d;
    logic [1:0]       full_q, full_d;
    logic [1:0][1:0]  bank_mode_q, bank_mode_d;
    logic             sop_err_q, sop_err_d;
    logic             in_xfer;
    logic             fill_done;
    logic [IDX_W-1:0] wr_addr;

    // Read side state
    logic             rb_q, rb_d;
    logic [IDX_W-1:0] rc_q, rc_d;
    logic [LOG_N-1:0] x_q, x_d, y_q, y_d;
    logic             rd_issue, rd_last, space_ok, pop;
    logic [IDX_W-1:0] rd_addr;
    scan_e            scan_mode;

    // RAM output stage
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [IDX_W-1:0]      rd_idx_q;
    logic                  rd_sop_q, rd_eop_q;

    // Two-entry output skid buffer
    beat_t      skid_q [2];
    beat_t      head;
    logic       skid_head_q;
    logic [1:0] skid_cnt_q;
    logic       skid_tail;

    // ---------------------------------------------------------------
    // Write side: a word carrying in_sop always restarts the block at 0.
    // ---------------------------------------------------------------
    assign in_ready  = ~full_q[wb_q];
    assign in_xfer   = in_valid & in_ready;
    assign wr_addr   = in_sop ? '0 : wc_q;
    assign fill_done = in_xfer && (wr_addr == LAST_IDX);
    assign sop_err   = sop_err_q;

    // Next-state for the fill counter, bank pointer and per-bank scan mode.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wc_d        = wc_q;
        wb_d        = wb_q;
        bank_mode_d = bank_mode_q;
        sop_err_d   = 1'b0;
        if (in_xfer) begin
            if (fill_done) begin
                wc_d = '0;
                wb_d = ~wb_q;
            end else begin
                wc_d = wr_addr + 1'b1;
            end
            if (wr_addr == '0) begin
                bank_mode_d[wb_q] = mode;
            end
            sop_err_d = in_sop && (wc_q != '0);
        end
    end

    // ---------------------------------------------------------------
    // Read side: issue a read only when the skid buffer is guaranteed a
    // slot for it once it comes out of the RAM a cycle later.
    // ---------------------------------------------------------------
    assign pop       = out_valid & out_ready;
    assign space_ok  = ({1'b0, skid_cnt_q} + {2'b00, rd_valid_q}) < (3'd2 + {2'b00, pop});
    assign rd_issue  = full_q[rb_q] & space_ok;
    assign rd_last   = rd_issue && (rc_q == LAST_IDX);
    assign rd_addr   = IDX_W'({y_q, x_q});
    assign scan_mode = scan_e'(bank_mode_q[rb_q]);

    // Scan generator: step (x,y) in the order latched for the bank being read.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        rc_d = rc_q;
        rb_d = rb_q;
        if (rd_issue) begin
            if (rd_last) begin
                x_d  = '0;
                y_d  = '0;
                rc_d = '0;
                rb_d = ~rb_q;
            end else begin
                rc_d = rc_q + 1'b1;
                case (scan_mode)
                    SCAN_RASTER: begin
                        if (x_q == EDGE) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                    SCAN_COLUMN: begin
                        if (y_q == EDGE) begin
                            y_d = '0;
                            x_d = x_q + 1'b1;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end
                    default: begin
                        // Even diagonal moves up-right, odd moves down-left;
                        // at an edge step onto the next diagonal instead.
                        if (!(x_q[0] ^ y_q[0])) begin
                            if (x_q == EDGE) begin
                                y_d = y_q + 1'b1;
                            end else if (y_q == '0) begin
                                x_d = x_q + 1'b1;
                            end else begin
                                x_d = x_q + 1'b1;
                                y_d = y_q - 1'b1;
                            end
                        end else begin
                            if (y_q == EDGE) begin
                                x_d = x_q + 1'b1;
                            end else if (x_q == '0) begin
                                y_d = y_q + 1'b1;
                            end else begin
                                x_d = x_q - 1'b1;
                                y_d = y_q + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Full flags: fill-complete and read-release always hit different banks.
    always_comb begin
        full_d = full_q;
        if (fill_done) begin
            full_d[wb_q] = 1'b1;
        end
        if (rd_last) begin
            full_d[rb_q] = 1'b0;
        end
    end

    // Block RAM: one write port for the fill bank, one synchronous read port.
    always_ff @(posedge clk) begin
        // NOTE: the RAM has no reset; stale contents are never read because the full flags are reset.
        if (in_xfer) begin
            mem_q[{wb_q, wr_addr}] <= in_data;
        end
        if (rd_issue) begin
            rd_data_q <= mem_q[{rb_q, rd_addr}];
        end
    end

    // Control registers for both sides plus the sideband that follows the RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc_q        <= '0;
            wb_q        <= 1'b0;
            full_q      <= '0;
            bank_mode_q <= '0;
            sop_err_q   <= 1'b0;
            rc_q        <= '0;
            rb_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            rd_valid_q  <= 1'b0;
            rd_idx_q    <= '0;
            rd_sop_q    <= 1'b0;
            rd_eop_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            wc_q        <= wc_d;
            wb_q        <= wb_d;
            full_q      <= full_d;
            bank_mode_q <= bank_mode_d;
            sop_err_q   <= sop_err_d;
            rc_q        <= rc_d;
            rb_q        <= rb_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rd_valid_q  <= rd_issue;
            if (rd_issue) begin
                rd_idx_q <= rd_addr;
                rd_sop_q <= (rc_q == '0);
                rd_eop_q <= rd_last;
            end
        end
    end

    // ---------------------------------------------------------------
    // Output skid buffer: holds the head stable while out_ready is low.
    // ---------------------------------------------------------------
    assign skid_tail = skid_head_q ^ skid_cnt_q[0];
    assign head      = skid_q[skid_head_q];
    assign out_valid = (skid_cnt_q != 2'd0);
    assign out_data  = head.data;
    assign out_idx   = head.idx;
    assign out_sop   = head.sop;
    assign out_eop   = head.eop;

    // Push RAM results, pop on output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                skid_q[i] <= '0;
            end
            skid_head_q <= 1'b0;
            skid_cnt_q  <= 2'd0;
        end else begin
            if (rd_valid_q) begin
                skid_q[skid_tail] <= '{data: rd_data_q, idx: rd_idx_q, sop: rd_sop_q, eop: rd_eop_q};
            end
            if (pop) begin
                skid_head_q <= ~skid_head_q;
            end
            skid_cnt_q <= skid_cnt_q + 2'(rd_valid_q) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_zigzag_reorder_pp.sv
// Directed bench for zigzag_reorder_pp: an N=8 instance for zigzag order,
// latency, streaming, backpressure, mid-block restart and reset, and an
// N=4 instance for the three scan orders.
module tb_zigzag_reorder_pp;

    localparam int DW = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int zz8 [64] = '{ 0,  1,  8, 16,  9,  2,  3, 10,
                     17, 24, 32, 25, 18, 11,  4,  5,
                     12, 19, 26, 33, 40, 48, 41, 34,
                     27, 20, 13,  6,  7, 14, 21, 28,
                     35, 42, 49, 56, 57, 50, 43, 36,
                     29, 22, 15, 23, 30, 37, 44, 51,
                     58, 59, 52, 45, 38, 31, 39, 46,
                     53, 60, 61, 54, 47, 55, 62, 63};
    int zz4 [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

    // ---------------- N=8 instance ----------------
    logic          a_iv = 1'b0, a_isop = 1'b0, a_or = 1'b1;
    logic [DW-1:0] a_id = '0;
    logic [1:0]    a_mode = 2'd0;
    logic          a_ir, a_ov, a_osop, a_oeop, a_serr;
    logic [DW-1:0] a_od;
    logic [5:0]    a_oidx;

    zigzag_reorder_pp #(.DATA_WIDTH(DW), .N(8)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_sop(a_isop), .mode(a_mode),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_idx(a_oidx),
        .out_sop(a_osop), .out_eop(a_oeop), .sop_err(a_serr)
    );

    // ---------------- N=4 instance ----------------
    logic          b_iv = 1'b0, b_isop = 1'b0, b_or = 1'b1;
    logic [DW-1:0] b_id = '0;
    logic [1:0]    b_mode = 2'd0;
    logic          b_ir, b_ov, b_osop, b_oeop, b_serr;
    logic [DW-1:0] b_od;
    logic [3:0]    b_oidx;

    zigzag_reorder_pp #(.DATA_WIDTH(DW), .N(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_sop(b_isop), .mode(b_mode),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_idx(b_oidx),
        .out_sop(b_osop), .out_eop(b_oeop), .sop_err(b_serr)
    );

    // ---------------- output monitors (sampled on falling edge) ----------------
    int a_dq[$], a_iq[$], a_fq[$], a_cq[$];
    int b_dq[$], b_iq[$], b_fq[$];
    int a_first = -1, a_last = 0, a_serr_cnt = 0, a_stall = 0, a_hold_err = 0;
    logic           a_hold = 1'b0;
    logic [DW+7:0]  a_snap = '0;

    always @(negedge clk) begin
        if (a_ov && a_or) begin
            a_dq.push_back(int'(a_od));
            a_iq.push_back(int'(a_oidx));
            a_fq.push_back(int'({a_osop, a_oeop}));
            a_cq.push_back(cyc);
        end
        if (a_ov && a_first < 0) a_first = cyc;
        if (a_serr) a_serr_cnt++;
        if (a_iv && !a_ir) a_stall++;
        if (a_hold && (!a_ov || {a_od, a_oidx, a_osop, a_oeop} != a_snap)) a_hold_err++;
        a_hold = a_ov && !a_or;
        a_snap = {a_od, a_oidx, a_osop, a_oeop};
    end

    always @(negedge clk) begin
        if (b_ov && b_or) begin
            b_dq.push_back(int'(b_od));
            b_iq.push_back(int'(b_oidx));
            b_fq.push_back(int'({b_osop, b_oeop}));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic a_put(input int d, input logic sop, input logic [1:0] m);
        int t = 0;
        a_iv = 1'b1; a_id = DW'(d); a_isop = sop; a_mode = m;
        @(negedge clk);
        while (!a_ir && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!a_ir) check("a_in_timeout", 0, 1);
        @(posedge clk);
        #1;
        a_last = cyc;
        a_iv = 1'b0; a_isop = 1'b0;
    endtask

    task automatic b_put(input int d, input logic sop, input logic [1:0] m);
        int t = 0;
        b_iv = 1'b1; b_id = DW'(d); b_isop = sop; b_mode = m;
        @(negedge clk);
        while (!b_ir && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!b_ir) check("b_in_timeout", 0, 1);
        @(posedge clk);
        #1;
        b_iv = 1'b0; b_isop = 1'b0;
    endtask

    task automatic a_block(input int base, input int gap);
        for (int k = 0; k < 64; k++) begin
            if (gap > 0) idle($urandom_range(0, gap));
            a_put(base + k, k == 0, 2'd0);
        end
    endtask

    task automatic a_wait(input string tag, input int n);
        int t = 0;
        while (a_dq.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check(tag, a_dq.size(), n);
    endtask

    task automatic b_wait(input string tag, input int n);
        int t = 0;
        while (b_dq.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(tag, b_dq.size(), n);
    endtask

    task automatic a_clear();
        a_dq.delete(); a_iq.delete(); a_fq.delete(); a_cq.delete();
    endtask

    // Blocks of ramp data base=64*b, zigzag order, flags on first/last.
    task automatic a_check_blocks(input string tag, input int nblk);
        for (int i = 0; i < 64 * nblk; i++) begin
            int j = i % 64;
            check($sformatf("%s_data[%0d]", tag, i), a_dq[i], 64 * (i / 64) + zz8[j]);
            check($sformatf("%s_idx[%0d]", tag, i), a_iq[i], zz8[j]);
            check($sformatf("%s_flags[%0d]", tag, i), a_fq[i], (j == 0 ? 2 : 0) + (j == 63 ? 1 : 0));
        end
    endtask

    function automatic int b_exp(input int m, input int i);
        case (m)
            1:       return i;
            2:       return (i % 4) * 4 + i / 4;
            default: return zz4[i];
        endcase
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        // Reset values while reset is held
        #1;
        check("rst_a_in_ready", a_ir, 1);
        check("rst_a_out_valid", a_ov, 0);
        check("rst_a_out_data", a_od, 0);
        check("rst_a_out_idx", a_oidx, 0);
        check("rst_a_sop_eop", {a_osop, a_oeop}, 0);
        check("rst_a_sop_err", a_serr, 0);
        check("rst_b_in_ready", b_ir, 1);
        check("rst_b_out_valid", b_ov, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // N=8 zigzag ramp, latency, sop/eop, idx == data
        a_clear();
        a_first = -1;
        a_block(0, 0);
        a_wait("zz8_count", 64);
        check("zz8_latency", a_first - a_last, 2);
        a_check_blocks("zz8", 1);
        idle(4);

        // N=4 scan orders; mode input changes after k=0 and must be ignored
        for (int m = 0; m < 4; m++) begin
            b_dq.delete(); b_iq.delete(); b_fq.delete();
            for (int k = 0; k < 16; k++) begin
                b_put(k, k == 0, (k == 0) ? 2'(m) : ~2'(m));
            end
            b_wait($sformatf("n4_m%0d_count", m), 16);
            for (int i = 0; i < 16; i++) begin
                check($sformatf("n4_m%0d_data[%0d]", m, i), b_dq[i], b_exp(m, i));
                check($sformatf("n4_m%0d_idx[%0d]", m, i), b_iq[i], b_exp(m, i));
                check($sformatf("n4_m%0d_flags[%0d]", m, i), b_fq[i], (i == 0 ? 2 : 0) + (i == 15 ? 1 : 0));
            end
            idle(3);
        end

        // Four back-to-back N=8 blocks: no stalls, continuous output
        a_clear();
        a_stall = 0;
        for (int b = 0; b < 4; b++) a_block(64 * b, 0);
        a_wait("b2b_count", 256);
        check("b2b_in_stall", a_stall, 0);
        check("b2b_out_span", a_cq[255] - a_cq[0], 255);
        a_check_blocks("b2b", 4);
        idle(4);

        // Random input gaps and 50% out_ready
        a_clear();
        a_hold_err = 0;
        fork
            begin
                for (int b = 0; b < 3; b++) a_block(64 * b, 2);
            end
            begin
                int t = 0;
                while (a_dq.size() < 192 && t < 20000) begin
                    @(posedge clk);
                    #1;
                    a_or = 1'($urandom_range(0, 1));
                    t++;
                end
                a_or = 1'b1;
            end
        join
        a_wait("rnd_count", 192);
        check("rnd_hold_stable", a_hold_err, 0);
        a_check_blocks("rnd", 3);
        idle(4);

        // Mid-block in_sop: 20 discarded words, then a restarted block
        a_clear();
        a_serr_cnt = 0;
        for (int k = 0; k < 20; k++) a_put(900 + k, k == 0, 2'd0);
        a_put(100, 1'b1, 2'd0);
        for (int k = 1; k < 64; k++) a_put(k, 1'b0, 2'd0);
        a_wait("sop_count", 64);
        idle(10);
        check("sop_no_extra", a_dq.size(), 64);
        check("sop_err_pulses", a_serr_cnt, 1);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("sop_data[%0d]", i), a_dq[i], (zz8[i] == 0) ? 100 : zz8[i]);
            check($sformatf("sop_idx[%0d]", i), a_iq[i], zz8[i]);
        end
        check("sop_first_flags", a_fq[0], 2);

        // Asynchronous reset in the middle of a drain
        a_clear();
        for (int k = 0; k < 64; k++) a_put(63 - k, k == 0, 2'd0);
        a_wait("mid_rst_count", 30);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", a_ov, 0);
        check("mid_rst_out_data", a_od, 0);
        check("mid_rst_out_idx", a_oidx, 0);
        check("mid_rst_sop_eop", {a_osop, a_oeop}, 0);
        check("mid_rst_in_ready", a_ir, 1);
        check("mid_rst_sop_err", a_serr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        a_clear();
        for (int k = 0; k < 64; k++) a_put(63 - k, k == 0, 2'd0);
        a_wait("post_rst_count", 64);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("post_rst_data[%0d]", i), a_dq[i], 63 - zz8[i]);
            check($sformatf("post_rst_idx[%0d]", i), a_iq[i], zz8[i]);
        end
        idle(4);
        check("final_in_ready", a_ir, 1);
        check("final_out_valid", a_ov, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zigzag_reorder_pp.md
# zigzag_reorder_pp

Parametrised coefficient reorder stage between the 2-D DCT and the quantizer/entropy coder. It accepts N×N coefficient blocks in raster order, buffers them in a ping-pong pair of block RAMs, and emits each block in a run-time-selectable scan order (zigzag, raster or column-major). Ready/valid flow control is used on both sides, so back-to-back blocks stream at one coefficient per cycle with no dead cycles between blocks.

## Interface
- DATA_WIDTH, 10, coefficient width in bits.
- N, 8, block edge; power of two, 2..16. Block holds N*N coefficients.
- IDX_W, 2*$clog2(N), derived; width of the raster index.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input coefficient present.
- in_ready  out  1  stage can accept a coefficient this cycle.
- in_data  in  DATA_WIDTH  coefficient, raster order (k = y*N + x).
- in_sop  in  1  first coefficient of a block.
- mode  in  2  scan order, sampled on the accepting edge of coefficient k=0. 0 zigzag, 1 raster, 2 column-major, 3 treated as zigzag.
- out_valid  out  1  output coefficient present.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_WIDTH  reordered coefficient.
- out_idx  out  IDX_W  raster index of out_data (y*N + x).
- out_sop  out  1  first output of a block; qualified by out_valid.
- out_eop  out  1  last output of a block; qualified by out_valid.
- sop_err  out  1  one-cycle pulse: in_sop seen mid-block.

## Operation
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Two banks, each N*N × DATA_WIDTH with a full flag and a latched mode. The write pointer wb selects the bank being filled. Write counter wc runs 0..N*N-1.
- in_ready = !full[wb].
- On each input transfer, write the coefficient to bank wb at address wc, then wc++.
- On the transfer with wc = N*N-1: set full[wb], toggle wb, wc←0.
- in_sop on a transfer with wc≠0: discard the partial block, store this word at address 0, wc←1, and pulse sop_err on the next cycle.
- in_sop on a transfer with wc=0: normal. A block without in_sop at wc=0 is accepted as-is.
- Read side: bank rb is scanned when full[rb] is set. A scan generator produces (x,y) in the latched order.
  - Zigzag: diagonals d = x+y, 0..2N-2. For even d, x increases. For odd d, x decreases. Coordinates are clamped to the array.
  - Raster: k = 0..N*N-1.
  - Column-major: x outer, y inner.
- Read address = y*N + x. The RAM read is synchronous with 1-cycle latency. The read pipeline plus a 2-entry output skid buffer gives full throughput under arbitrary out_ready.
- A read is issued only if the buffer will have space, so no coefficient is dropped or duplicated.
- When the final read of a bank is issued: clear full[rb] and toggle rb. The bank becomes writable on the next cycle.
- out_sop and out_eop travel with the data through the pipeline. out_idx equals the read address.
- Reset, including mid-block: all counters, pointers and full flags clear, the skid buffer empties, and partial data is lost. RAM contents are not reset.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_sop=0, out_eop=0, sop_err=0.

## Timing
- Latency: the last coefficient of a block is accepted at edge E. The first read is issued in cycle E..E+1, and out_valid rises after edge E+2 (2 cycles).
- Sustained throughput is 1 coefficient/cycle when out_ready=1. Block k+1 fills while block k drains.
- in_ready drops only when both banks are full. It rises the cycle after the final read of a bank is issued.
- Simultaneous fill-complete of bank A and read-release of bank B at the same edge: both take effect, and in_ready stays 1.
- out_valid, once high, holds with stable data, idx, sop and eop until accepted.
- Mode change while a block is filling does not affect that block. The mode is latched at k=0 acceptance.

## Test plan
- N=8, mode 0, in_data=k for k=0..63, out_ready=1 → output 0,1,8,16,9,2,3,10,17,24,…,55,62,63. out_sop on 0, out_eop on 63, out_idx=out_data, first out_valid 2 cycles after last input.
- N=4, mode 0, ramp 0..15 → 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15. Mode 2 → 0,4,8,12,1,5,…,15. Mode 1 → 0..15.
- N=8, 4 back-to-back blocks, in_valid=1, out_ready=1 → in_ready never low, out_valid continuous for 256 cycles after initial latency.
- Random out_ready (50%) with random in_valid → the output sequence matches the reference scan exactly, with no loss or duplication. in_ready is low only when both banks are full.
- Send 20 words, then in_sop with data 100 followed by a ramp → sop_err pulses once. The emitted block starts at out_idx 0 with data 100, and no output comes from the discarded words.
- Assert rst_n low mid-drain at output 30 → all outputs go to reset values asynchronously. After release, a fresh block reorders correctly.
